ram_req_ctrl: RTL and testbench

- Request-side controller sitting directly upstream of the 8-entry RAM (`ram` block) and driving its wr_*/rd_* ports.
- Accepts independent write and read requests over valid/ready handshakes and issues them to the RAM through registered ports.
- Resolves same-cycle read/write address collisions and rejects out-of-range addresses.
- Returns read data through a credit-limited response FIFO with valid/ready back-pressure.

---
 rtl/ram_req_ctrl_pkg.sv | 19 +
 rtl/ram_req_ctrl_rsp_fifo.sv | 57 +++++
 rtl/ram_req_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ram_req_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_req_ctrl_pkg.sv
// Shared types and helpers for the RAM request controller.
// Holds the response record stored in the response FIFO, the width of the
// optional statistics counters, and the address range check used by both
// request paths.
package ram_req_ctrl_pkg;

  localparam int RSP_DATA_W = 8;
  localparam int STAT_W     = 16;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] data;
    logic                  err;
  } ram_rsp_t;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/ram_req_ctrl_rsp_fifo.sv
// ram_rsp_fifo: synchronous FIFO for read responses.
// Power-of-two depth so the pointers wrap naturally. A pop is ignored when
// empty and a push is ignored when full unless a pop frees the slot on the
// same edge. Storage is not reset; only pointers and count are.
module ram_rsp_fifo
  import ram_req_ctrl_pkg::*;
#(
  parameter type T     = ram_rsp_t,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  T            push_data,
  input  logic        pop,
  output T            head,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  T              mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: request-side controller in front of the 8-entry RAM.
// Registers write/read requests onto the RAM ports, stalls a read that hits
// the address being written in the same cycle, tags every accepted read in a
// valid/err shift pipe matching the RAM read latency, and queues results in
// a response FIFO whose depth is also the outstanding-read credit limit.
// Optional build macro: RAM_REQ_CTRL_STATS_EN adds saturating request
// counters stat_wr_cnt, stat_rd_cnt and stat_err_cnt.
module ram_req_ctrl
  import ram_req_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int RD_LATENCY = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic                  rd_rsp_err,
  output logic                  ram_wr_enb,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_enb,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
`ifdef RAM_REQ_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_wr_cnt,
  output logic [STAT_W-1:0]     stat_rd_cnt,
  output logic [STAT_W-1:0]     stat_err_cnt
`endif
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 2;
  localparam int FC_W  = $clog2(RSP_DEPTH) + 1;

  logic                wr_in_range;
  logic                rd_in_range;
  logic                hazard;
  logic                wr_acc;
  logic                rd_acc;
  logic [CNT_W-1:0]    inflight;
  logic                credit_ok;
  logic [RD_LATENCY:0] tag_vld_p;
  logic [RD_LATENCY:0] tag_err_p;
  ram_rsp_t            push_rsp;
  ram_rsp_t            head_rsp;
  logic [FC_W-1:0]     fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                rsp_pop;

  assign wr_in_range = addr_in_range(32'(wr_req_addr), int'(DEPTH));
  assign rd_in_range = addr_in_range(32'(rd_req_addr), int'(DEPTH));

  // Out-of-range collisions never stall: the write is dropped anyway.
  assign hazard = wr_req_valid && rd_req_valid && (wr_req_addr == rd_req_addr) && wr_in_range;

  // Reads still in the tag pipe that have not yet reached the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LATENCY; i++) inflight = inflight + CNT_W'(tag_vld_p[i]);
  end

  assign credit_ok    = (inflight + CNT_W'(fifo_count)) < CNT_W'(RSP_DEPTH);
  assign wr_req_ready = !rst;
  assign rd_req_ready = !rst && credit_ok && !hazard && !fifo_full;
  assign wr_acc       = wr_req_valid && wr_req_ready;
  assign rd_acc       = rd_req_valid && rd_req_ready;

  // Stage p0: register accepted requests onto the RAM ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wr_enb  <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_rd_enb  <= 1'b0;
      ram_rd_addr <= '0;
    end else begin
      ram_wr_enb <= wr_acc && wr_in_range;
      ram_rd_enb <= rd_acc && rd_in_range;
      if (wr_acc && wr_in_range) begin
        ram_wr_addr <= wr_req_addr;
        ram_wr_data <= wr_req_data;
      end
      if (rd_acc && rd_in_range) ram_rd_addr <= rd_req_addr;
    end
  end

  // Tag pipe: one slot per edge until the RAM data is valid at the exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_p <= '0;
      tag_err_p <= '0;
    end else begin
      tag_vld_p <= {tag_vld_p[RD_LATENCY-1:0], rd_acc};
      tag_err_p <= {tag_err_p[RD_LATENCY-1:0], rd_acc && !rd_in_range};
    end
  end

  // Pipe exit: error tags carry zero data instead of whatever the RAM shows.
  always_comb begin
    push_rsp      = '0;
    push_rsp.err  = tag_err_p[RD_LATENCY];
    push_rsp.data = tag_err_p[RD_LATENCY] ? '0 : RSP_DATA_W'(ram_rd_data);
  end

  assign rsp_pop = rd_rsp_valid && rd_rsp_ready;

  ram_rsp_fifo #(
    .T     (ram_rsp_t),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_vld_p[RD_LATENCY]),
    .push_data (push_rsp),
    .pop       (rsp_pop),
    .head      (head_rsp),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd_rsp_valid = !fifo_empty;
  assign rd_rsp_data  = fifo_empty ? '0 : DATA_WIDTH'(head_rsp.data);
  assign rd_rsp_err   = !fifo_empty && head_rsp.err;

`ifdef RAM_REQ_CTRL_STATS_EN
  logic [1:0] err_inc;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] cnt, input logic [1:0] inc);
    logic [STAT_W:0] sum;
    sum = {1'b0, cnt} + (STAT_W+1)'(inc);
    return sum[STAT_W] ? '1 : sum[STAT_W-1:0];
  endfunction

  assign err_inc = {1'b0, wr_acc && !wr_in_range} + {1'b0, rd_acc && !rd_in_range};

  // Saturating counters of accepted and out-of-range requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wr_cnt  <= '0;
      stat_rd_cnt  <= '0;
      stat_err_cnt <= '0;
    end else begin
      stat_wr_cnt  <= sat_add(stat_wr_cnt, {1'b0, wr_acc});
      stat_rd_cnt  <= sat_add(stat_rd_cnt, {1'b0, rd_acc});
      stat_err_cnt <= sat_add(stat_err_cnt, err_inc);
    end
  end
`endif

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Testbench for ram_req_ctrl: directed scenarios plus randomized traffic,
// checked against a transaction-level model (memory array, queue of expected
// responses with due cycles, outstanding-request credit count).
module tb_ram_req_ctrl;

  localparam int RSP_DEPTH = 4;
  localparam int RD_LAT    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req_valid = 1'b0;
  logic        wr_req_ready;
  logic [15:0] wr_req_addr = '0;
  logic [7:0]  wr_req_data = '0;
  logic        rd_req_valid = 1'b0;
  logic        rd_req_ready;
  logic [15:0] rd_req_addr = '0;
  logic        rd_rsp_valid;
  logic        rd_rsp_ready = 1'b0;
  logic [7:0]  rd_rsp_data;
  logic        rd_rsp_err;
  logic        ram_wr_enb;
  logic [15:0] ram_wr_addr;
  logic [7:0]  ram_wr_data;
  logic        ram_rd_enb;
  logic [15:0] ram_rd_addr;
  logic [7:0]  ram_rd_data = 8'h00;
`ifdef RAM_REQ_CTRL_STATS_EN
  logic [15:0] stat_wr_cnt;
  logic [15:0] stat_rd_cnt;
  logic [15:0] stat_err_cnt;
`endif

  ram_req_ctrl #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .DEPTH      (8),
    .RD_LATENCY (RD_LAT),
    .RSP_DEPTH  (RSP_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_data  (rd_rsp_data),
    .rd_rsp_err   (rd_rsp_err),
    .ram_wr_enb   (ram_wr_enb),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data),
    .ram_rd_enb   (ram_rd_enb),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data)
`ifdef RAM_REQ_CTRL_STATS_EN
    ,
    .stat_wr_cnt  (stat_wr_cnt),
    .stat_rd_cnt  (stat_rd_cnt),
    .stat_err_cnt (stat_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural RAM with one-edge read latency.
  logic [7:0] ram_mem [8] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_wr_enb) ram_mem[ram_wr_addr[2:0]] <= ram_wr_data;
    if (ram_rd_enb) ram_rd_data <= ram_mem[ram_rd_addr[2:0]];
  end

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         due;
  } rsp_t;

  rsp_t        q[$];
  logic [7:0]  mem [8];
  int          cyc;
  int          n_chk;
  int          n_fail;
  int          n_wr;
  int          n_rd;
  int          n_err;
  logic        want_wr_enb;
  logic [15:0] want_wr_addr;
  logic [7:0]  want_wr_data;
  logic        want_rd_enb;
  logic [15:0] want_rd_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock: check registered outputs, drive a request set, update model.
  task automatic cycle(input logic wv, input logic [15:0] wa, input logic [7:0] wd,
                       input logic rv, input logic [15:0] ra, input logic rr, output logic acc);
    logic head_vld, hz, want_rdy, racc, pop;
    rsp_t e;
    chk("ram_wr_enb", 32'(ram_wr_enb), 32'(want_wr_enb));
    if (want_wr_enb) begin
      chk("ram_wr_addr", 32'(ram_wr_addr), 32'(want_wr_addr));
      chk("ram_wr_data", 32'(ram_wr_data), 32'(want_wr_data));
    end
    chk("ram_rd_enb", 32'(ram_rd_enb), 32'(want_rd_enb));
    if (want_rd_enb) chk("ram_rd_addr", 32'(ram_rd_addr), 32'(want_rd_addr));
    head_vld = (q.size() > 0) && (q[0].due <= cyc);
    chk("rsp_valid", 32'(rd_rsp_valid), 32'(head_vld));
    if (head_vld) begin
      chk("rsp_data", 32'(rd_rsp_data), 32'(q[0].data));
      chk("rsp_err", 32'(rd_rsp_err), 32'(q[0].err));
    end
    wr_req_valid = wv; wr_req_addr = wa; wr_req_data = wd;
    rd_req_valid = rv; rd_req_addr = ra; rd_rsp_ready = rr;
    #1;
    hz       = wv && rv && (wa == ra) && (wa < 16'd8);
    want_rdy = (q.size() < RSP_DEPTH) && !hz;
    chk("rd_req_ready", 32'(rd_req_ready), 32'(want_rdy));
    chk("wr_req_ready", 32'(wr_req_ready), 32'd1);
    acc  = rv && rd_req_ready;
    racc = rv && want_rdy;
    pop  = head_vld && rr;
    @(posedge clk);
    cyc++;
    if (pop) void'(q.pop_front());
    if (racc) begin
      e.err  = (ra >= 16'd8);
      e.data = e.err ? 8'h00 : mem[ra[2:0]];
      e.due  = cyc + 1 + RD_LAT;
      q.push_back(e);
      n_rd++;
      if (e.err) n_err++;
    end
    if (wv) begin
      n_wr++;
      if (wa < 16'd8) mem[wa[2:0]] = wd;
      else n_err++;
    end
    want_wr_enb  = wv && (wa < 16'd8);
    want_wr_addr = wa;
    want_wr_data = wd;
    want_rd_enb  = racc && (ra < 16'd8);
    want_rd_addr = ra;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 16'd0, 8'd0, 1'b0, 16'd0, rr, a);
  endtask

  // Reset asserted at a falling edge, held across one rising edge.
  task automatic do_reset();
    rst = 1'b1;
    wr_req_valid = 1'b0; rd_req_valid = 1'b0; rd_rsp_ready = 1'b0;
    #1;
    chk("rst_wr_ready", 32'(wr_req_ready), 32'd0);
    chk("rst_rd_ready", 32'(rd_req_ready), 32'd0);
    chk("rst_ram_wr_enb", 32'(ram_wr_enb), 32'd0);
    chk("rst_ram_wr_addr", 32'(ram_wr_addr), 32'd0);
    chk("rst_ram_wr_data", 32'(ram_wr_data), 32'd0);
    chk("rst_ram_rd_enb", 32'(ram_rd_enb), 32'd0);
    chk("rst_ram_rd_addr", 32'(ram_rd_addr), 32'd0);
    chk("rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rd_rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rd_rsp_err), 32'd0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("rst_hold_valid", 32'(rd_rsp_valid), 32'd0);
    rst = 1'b0;
    q.delete();
    want_wr_enb = 1'b0;
    want_rd_enb = 1'b0;
    n_wr = 0; n_rd = 0; n_err = 0;
  endtask

  initial begin
    logic        a;
    int          n_acc;
    logic        wv, rv, rr;
    logic [15:0] wa, ra;
    cyc = 0; n_chk = 0; n_fail = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    @(negedge clk);
    do_reset();

    // Write then read back with latency check.
    cycle(1'b1, 16'd3, 8'hA5, 1'b0, 16'd0, 1'b1, a);
    cycle(1'b0, 16'd0, 8'h00, 1'b1, 16'd3, 1'b1, a);
    chk("wr_rd_acc", 32'(a), 32'd1);
    idle(4, 1'b1);

    // Same-cycle collision: read stalls, then sees the new data.
    cycle(1'b1, 16'd5, 8'h3C, 1'b1, 16'd5, 1'b1, a);
    chk("hazard_stall", 32'(a), 32'd0);
    cycle(1'b0, 16'd0, 8'h00, 1'b1, 16'd5, 1'b1, a);
    chk("hazard_retry", 32'(a), 32'd1);
    idle(4, 1'b1);

    // Credit limit with consumer stalled.
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 16'd0, 8'h00, 1'b1, 16'(i), 1'b0, a);
      if (a) n_acc++;
    end
    chk("credit_accepts", 32'(n_acc), 32'd4);
    idle(3, 1'b0);
    idle(6, 1'b1);
    n_acc = 0;
    for (int i = 4; i < 6; i++) begin
      cycle(1'b0, 16'd0, 8'h00, 1'b1, 16'(i), 1'b1, a);
      if (a) n_acc++;
    end
    chk("credit_rest", 32'(n_acc), 32'd2);
    idle(4, 1'b1);

    // Out-of-range read and write, then read back every location.
    cycle(1'b0, 16'd0, 8'h00, 1'b1, 16'd9, 1'b1, a);
    cycle(1'b1, 16'd12, 8'hFF, 1'b0, 16'd0, 1'b1, a);
    cycle(1'b1, 16'd9, 8'h77, 1'b1, 16'd9, 1'b1, a);
    chk("oor_collide_no_stall", 32'(a), 32'd1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 16'd0, 8'h00, 1'b1, 16'(i), 1'b1, a);
    idle(4, 1'b1);

    // Reset with two reads in flight and two responses queued.
    cycle(1'b0, 16'd0, 8'h00, 1'b1, 16'd1, 1'b0, a);
    cycle(1'b0, 16'd0, 8'h00, 1'b1, 16'd2, 1'b0, a);
    idle(2, 1'b0);
    cycle(1'b0, 16'd0, 8'h00, 1'b1, 16'd3, 1'b0, a);
    cycle(1'b0, 16'd0, 8'h00, 1'b1, 16'd4, 1'b0, a);
    do_reset();
    idle(5, 1'b1);

`ifdef RAM_REQ_CTRL_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(i), 8'(8'h10 + i), 1'b0, 16'd0, 1'b1, a);
    cycle(1'b0, 16'd0, 8'h00, 1'b1, 16'd0, 1'b1, a);
    cycle(1'b0, 16'd0, 8'h00, 1'b1, 16'd1, 1'b1, a);
    cycle(1'b0, 16'd0, 8'h00, 1'b1, 16'd9, 1'b1, a);
    chk("stat_wr", 32'(stat_wr_cnt), 32'd3);
    chk("stat_rd", 32'(stat_rd_cnt), 32'd3);
    chk("stat_err", 32'(stat_err_cnt), 32'd1);
    idle(4, 1'b1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      wv = ($urandom_range(0, 1) == 1);
      wa = 16'($urandom_range(0, 11));
      rv = ($urandom_range(0, 2) != 0);
      ra = ($urandom_range(0, 3) == 0) ? wa : 16'($urandom_range(0, 11));
      rr = ($urandom_range(0, 9) < 7);
      cycle(wv, wa, 8'($urandom), rv, ra, rr, a);
    end
    idle(8, 1'b1);

`ifdef RAM_REQ_CTRL_STATS_EN
    chk("stat_wr_rand", 32'(stat_wr_cnt), 32'(n_wr));
    chk("stat_rd_rand", 32'(stat_rd_cnt), 32'(n_rd));
    chk("stat_err_rand", 32'(stat_err_cnt), 32'(n_err));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
